sprite_pixel_serializer: RTL

- Upstream feeder of the sprite line buffer.
- Accepts one 8-pixel sprite sliver (4 bitplanes from graphics ROM, palette, X start, flip/shrink) per handshake.
- Emits one pixel step per pixel-enable, driving the line buffer's address-load/increment, clock strobe, active-low write and 4-bit colour index.
- Two-deep buffered (holding register + shifter), so the sprite fetch logic can run one sliver ahead.

---
 rtl/sprite_pixel_serializer_pkg.sv | 36 +++
 rtl/sprite_pixel_serializer_sliver_hold_reg.sv | 52 +++++
 rtl/sprite_pixel_serializer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sprite_pixel_serializer_pkg.sv
// Shared types and constants for the sprite pixel serializer.
// Holds the sliver bundle, field offsets and shifter state encoding.
package sprite_pixel_serializer_pkg;

    localparam int ADDR_W       = 8;
    localparam int LB_WIDTH_DEF = 192;

    localparam int P0_LSB = 0;
    localparam int P1_LSB = 8;
    localparam int P2_LSB = 16;
    localparam int P3_LSB = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    typedef struct packed {
        logic [31:0]       bitplanes;
        logic [ADDR_W-1:0] x;
        logic              cont;
        logic              hflip;
        logic [7:0]        shrink;
        logic [7:0]        pal;
    } sliver_t;

    // Colour of pixel idx: one bit from each plane, P3 is the MSB.
    function automatic logic [3:0] pixel_color(
        input logic [31:0] bp,
        input logic [2:0]  idx
    );
        return {bp[P3_LSB + 32'(idx)], bp[P2_LSB + 32'(idx)],
                bp[P1_LSB + 32'(idx)], bp[P0_LSB + 32'(idx)]};
    endfunction

endpackage

// File: rtl/sprite_pixel_serializer_sliver_hold_reg.sv
// One-deep valid/ready holding register for incoming slivers.
// Ports: in_valid_i/in_data_i/in_ready_o upstream; take_i/full_o/data_o downstream.
module sliver_hold_reg
    import sprite_pixel_serializer_pkg::*;
(
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    in_valid_i,
    input  sliver_t in_data_i,
    output logic    in_ready_o,
    input  logic    take_i,
    output logic    full_o,
    output logic    full_nx_o,
    output sliver_t data_o
);

    logic    full_q, full_d;
    logic    ready_q;
    sliver_t data_q, data_d;
    logic    accept;

    // Accept and take are exclusive: accept needs empty, take needs full.
    always_comb begin
        accept = in_valid_i & ready_q;
        full_d = full_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ~full_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o = ready_q;
    assign full_o     = full_q;
    assign full_nx_o  = full_d;
    assign data_o     = data_q;

endmodule

// File: rtl/sprite_pixel_serializer.sv
// Serialises 8-pixel sprite slivers into line-buffer write steps.
// Ports: sliver handshake in; LB_* strobes, colour, palette and busy out.
module sprite_pixel_serializer
    import sprite_pixel_serializer_pkg::*;
#(
    parameter int LB_WIDTH = LB_WIDTH_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ce_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_bitplanes_i,
    input  logic [ADDR_W-1:0] in_x_i,
    input  logic              in_cont_i,
    input  logic              in_hflip_i,
    input  logic [7:0]        in_shrink_i,
    input  logic [7:0]        in_pal_i,
    output logic              lb_ck_o,
    output logic              lb_load_o,
    output logic [ADDR_W-1:0] lb_addr_load_o,
    output logic              lb_we_o,
    output logic [3:0]        color_index_o,
    output logic [7:0]        spr_pal_o,
    output logic              busy_o
);

    localparam logic [ADDR_W:0] LB_LIMIT = (ADDR_W+1)'(LB_WIDTH);

    shift_state_e      state_q, state_d;
    logic [2:0]        slot_q, slot_d;
    sliver_t           cur_q, cur_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ck_q, ck_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] aload_q, aload_d;
    logic              we_q, we_d;
    logic [3:0]        col_q, col_d;
    logic              busy_q, busy_d;

    sliver_t    in_data, hold_data;
    logic       hold_full, hold_full_nx;
    logic       take;
    logic [2:0] pix_idx;
    logic       keep;
    logic [3:0] pix;

    assign in_data = '{bitplanes: in_bitplanes_i, x: in_x_i,
                       cont: in_cont_i, hflip: in_hflip_i,
                       shrink: in_shrink_i, pal: in_pal_i};

    sliver_hold_reg u_hold (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data),
        .in_ready_o (in_ready_o),
        .take_i     (take),
        .full_o     (hold_full),
        .full_nx_o  (hold_full_nx),
        .data_o     (hold_data)
    );

    // Refill on idle, or on the last slot so slivers run gap-free.
    always_comb begin
        take = 1'b0;
        unique case (state_q)
            ST_IDLE:  take = hold_full;
            ST_SHIFT: take = hold_full & ce_i & (slot_q == 3'd7);
            default:  take = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cur_d   = cur_q;
        first_d = first_q;
        addr_d  = addr_q;
        ck_d    = 1'b0;
        load_d  = load_q;
        aload_d = aload_q;
        we_d    = 1'b1;
        col_d   = col_q;
        pix_idx = cur_q.hflip ? slot_q : 3'd7 - slot_q;
        keep    = cur_q.shrink[3'd7 - slot_q];
        pix     = pixel_color(cur_q.bitplanes, pix_idx);

        if (state_q == ST_SHIFT && ce_i) begin
            if (keep) begin
                ck_d    = 1'b1;
                col_d   = pix;
                first_d = 1'b0;
                if (first_q && !cur_q.cont) begin
                    addr_d  = cur_q.x;
                    load_d  = 1'b0;
                    aload_d = cur_q.x;
                end else begin
                    addr_d = addr_q + 1'b1;
                    load_d = 1'b1;
                end
                // Transparent or offscreen pixels advance without writing.
                we_d = ~((pix != 4'd0) && ({1'b0, addr_d} < LB_LIMIT));
            end
            slot_d = slot_q + 3'd1;
            if (slot_q == 3'd7 && !hold_full) begin
                state_d = ST_IDLE;
            end
        end

        if (take) begin
            state_d = ST_SHIFT;
            slot_d  = 3'd0;
            cur_d   = hold_data;
            first_d = 1'b1;
        end

        busy_d = (state_d == ST_SHIFT) | hold_full_nx;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            slot_q  <= 3'd0;
            cur_q   <= '0;
            first_q <= 1'b1;
            addr_q  <= '0;
            ck_q    <= 1'b0;
            load_q  <= 1'b1;
            aload_q <= '0;
            we_q    <= 1'b1;
            col_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cur_q   <= cur_d;
            first_q <= first_d;
            addr_q  <= addr_d;
            ck_q    <= ck_d;
            load_q  <= load_d;
            aload_q <= aload_d;
            we_q    <= we_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
        end
    end

    assign lb_ck_o        = ck_q;
    assign lb_load_o      = load_q;
    assign lb_addr_load_o = aload_q;
    assign lb_we_o        = we_q;
    assign color_index_o  = col_q;
    assign spr_pal_o      = cur_q.pal;
    assign busy_o         = busy_q;

endmodule
